// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Host-side controller for a bit-serial SPI RAM. Each host request becomes
//   two 13-cycle SPI frames. A write sends the address frame and then the data
//   frame. A read sends the address frame and then the read-command frame,
//   waits for the turnaround, and shifts in one byte on MISO.
//
// Parameters
//   GAP    : SS_n-high cycles after every frame (1..15)
//   RD_LAT : turnaround cycles before the first MISO sample (1..7)
//
// Ports
//   clk, rst           : single rising-edge clock, synchronous active-high reset
//   req_valid/ready    : request handshake; accepted when both are high
//   req_write          : 1 = write, 0 = read
//   req_addr/req_wdata : RAM address and write data, captured at acceptance
//   done               : one-cycle pulse when a transaction completes
//   rsp_rdata          : last read result; held until the next read completes
//   busy               : high whenever the controller is not idle
//   SS_n, MOSI, MISO   : SPI link to the RAM
module spi_ram_master #(
  parameter int unsigned GAP    = 1,
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       done,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP_A,
    FRAME_B,
    RD_TURN,
    RD_SHIFT,
    GAP_B,
    DONE
  } state_t;

  localparam logic [3:0] FRAME_LAST = 4'd12;
  localparam logic [3:0] SHIFT_LAST = 4'd7;
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam logic [2:0] TURN_LAST  = 3'(RD_LAT - 1);

  state_t      state, state_n;
  logic [3:0]  fcnt, fcnt_n;   // frame bit index, also reused as RD_SHIFT bit count
  logic [3:0]  gcnt, gcnt_n;
  logic [2:0]  tcnt, tcnt_n;
  logic        accept;

  logic        wr_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  sr;

  logic [12:0] frame_bits;
  logic        link_n;
  logic        mosi_n;

  // Next-state and counter sequencing
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    gcnt_n  = gcnt;
    tcnt_n  = tcnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_n = FRAME_A;
          fcnt_n  = '0;
        end
      end
      FRAME_A: begin
        if (fcnt == FRAME_LAST) begin
          state_n = GAP_A;
          gcnt_n  = '0;
        end else begin
          fcnt_n = fcnt + 4'd1;
        end
      end
      GAP_A: begin
        if (gcnt == GAP_LAST) begin
          state_n = FRAME_B;
          fcnt_n  = '0;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      FRAME_B: begin
        if (fcnt == FRAME_LAST) begin
          if (wr_q) begin
            state_n = GAP_B;
            gcnt_n  = '0;
          end else begin
            state_n = RD_TURN;
            tcnt_n  = '0;
          end
        end else begin
          fcnt_n = fcnt + 4'd1;
        end
      end
      RD_TURN: begin
        if (tcnt == TURN_LAST) begin
          state_n = RD_SHIFT;
          fcnt_n  = '0;
        end else begin
          tcnt_n = tcnt + 3'd1;
        end
      end
      RD_SHIFT: begin
        if (fcnt == SHIFT_LAST) begin
          state_n = GAP_B;
          gcnt_n  = '0;
        end else begin
          fcnt_n = fcnt + 4'd1;
        end
      end
      GAP_B: begin
        if (gcnt == GAP_LAST) begin
          state_n = DONE;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so they change on the same
  // edge as the state register. The frame layout is
  // {0, selector, cmd[1:0], payload[7:0], 0}. The selector and cmd[1] are both
  // "is read", and cmd[0] is "second frame". The F0 bit is a constant 0, so
  // wr_q not being captured yet on the acceptance edge does not matter.
  always_comb begin
    frame_bits = '0;
    link_n     = 1'b0;
    mosi_n     = 1'b0;
    if (state_n == FRAME_B) begin
      frame_bits = {1'b0, ~wr_q, ~wr_q, 1'b1, (wr_q ? wdata_q : 8'h00), 1'b0};
    end else begin
      frame_bits = {1'b0, ~wr_q, ~wr_q, 1'b0, addr_q, 1'b0};
    end
    if (state_n == FRAME_A || state_n == FRAME_B) begin
      mosi_n = frame_bits[FRAME_LAST - fcnt_n];
    end
    link_n = (state_n == FRAME_A) || (state_n == FRAME_B) ||
             (state_n == RD_TURN) || (state_n == RD_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fcnt      <= '0;
      gcnt      <= '0;
      tcnt      <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sr        <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      gcnt  <= gcnt_n;
      tcnt  <= tcnt_n;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD_SHIFT) begin
        sr <= {sr[6:0], MISO};
      end
      SS_n      <= ~link_n;
      MOSI      <= mosi_n;
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      if (state_n == DONE && !wr_q) begin
        rsp_rdata <= sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master
//   Directed test of spi_ram_master. dut0 uses the default parameters and
//   dut1 uses GAP=3, RD_LAT=2. A behavioural SPI RAM per instance decodes the
//   MOSI frames, stores write data and drives MISO for reads. It also logs
//   frames and SS_n-high run lengths so they can be checked.
module tb_spi_ram_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, valid0, write0, ready0, done0, busy0;
  logic [7:0] addr0, wdata0, rdata0;
  logic       rst1, valid1, write1, ready1, done1, busy1;
  logic [7:0] addr1, wdata1, rdata1;
  logic [1:0] ss_v, mosi_v, miso_v;

  int checks = 0;
  int fails  = 0;

  spi_ram_master dut0 (
    .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0),
    .req_write(write0), .req_addr(addr0), .req_wdata(wdata0),
    .done(done0), .rsp_rdata(rdata0), .busy(busy0),
    .SS_n(ss_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0])
  );

  spi_ram_master #(.GAP(3), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_write(write1), .req_addr(addr1), .req_wdata(wdata1),
    .done(done1), .rsp_rdata(rdata1), .busy(busy1),
    .SS_n(ss_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1])
  );

  // SPI RAM slave models and link monitors
  logic [7:0]  mem [2][256];
  int          lat_cfg [2] = '{1, 2};
  int          bc [2] = '{0, 0};
  int          hi [2] = '{0, 0};
  logic [12:0] sh [2];
  logic [7:0]  ad [2];
  bit          rdp [2] = '{1'b0, 1'b0};
  logic [12:0] frames0 [$];
  int          gaps0 [$];
  int          gaps1 [$];

  always @(negedge clk) begin
    logic [7:0] pl;
    logic [7:0] cur;
    int         j;
    for (int i = 0; i < 2; i++) begin
      miso_v[i] = 1'b1;
      if (ss_v[i] === 1'b0) begin
        if (bc[i] == 0) begin
          if (i == 0) gaps0.push_back(hi[i]);
          else        gaps1.push_back(hi[i]);
        end
        hi[i] = 0;
        if (bc[i] <= 12) begin
          sh[i] = {sh[i][11:0], mosi_v[i]};
          if (bc[i] == 12) begin
            pl = sh[i][8:1];
            case (sh[i][10:9])
              2'b00, 2'b10: ad[i] = pl;
              2'b01:        mem[i][ad[i]] = pl;
              default:      rdp[i] = 1'b1;
            endcase
            if (i == 0) frames0.push_back(sh[i]);
          end
        end else if (rdp[i]) begin
          j = bc[i] - 13 - lat_cfg[i];
          if (j >= 0 && j < 8) begin
            cur = mem[i][ad[i]];
            miso_v[i] = cur[3'(7 - j)];
          end
        end
        bc[i]++;
      end else begin
        bc[i]  = 0;
        hi[i]++;
        rdp[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request to dut0 and return in the first cycle after acceptance.
  task automatic accept0(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    valid0 = 1'b1; write0 = wr; addr0 = a; wdata0 = d;
    while (ready0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept0_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    if (!hold) valid0 = 1'b0;
  endtask

  // Count cycles (the first post-acceptance cycle is 1) until done is seen.
  task automatic wait_done0(input bit tog, output int lat);
    lat = 1;
    while (done0 !== 1'b1 && lat < 200) begin
      if (tog) begin
        addr0  = ~addr0;
        wdata0 = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int pulses;
    rst0 = 1'b1; valid0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    rst1 = 1'b1; valid1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem[1][8'h10] = 8'h5A;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ss_n",  32'(ss_v[0]),   32'd1);
    chk("rst_mosi",  32'(mosi_v[0]), 32'd0);
    chk("rst_ready", 32'(ready0),    32'd0);
    chk("rst_busy",  32'(busy0),     32'd0);
    chk("rst_done",  32'(done0),     32'd0);
    chk("rst_rdata", 32'(rdata0),    32'h00);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("ready_after_rst",  32'(ready0), 32'd1);
    chk("ready1_after_rst", 32'(ready1), 32'd1);

    // Write 0xFD <- 0xFC
    frames0.delete(); gaps0.delete();
    accept0(1'b1, 8'hFD, 8'hFC, 1'b0);
    chk("wr_busy", 32'(busy0), 32'd1);
    wait_done0(1'b0, lat);
    chk("wr_latency",      32'(lat),       32'd29);
    chk("wr_done_ss_n",    32'(ss_v[0]),   32'd1);
    chk("wr_done_mosi",    32'(mosi_v[0]), 32'd0);
    chk("wr_rdata_keep",   32'(rdata0),    32'h00);
    chk("wr_frame_a",      32'(frames0[0]), 32'({1'b0, 1'b0, 2'b00, 8'hFD, 1'b0}));
    chk("wr_frame_b",      32'(frames0[1]), 32'({1'b0, 1'b0, 2'b01, 8'hFC, 1'b0}));
    chk("wr_gap",          32'(gaps0[1]),  32'd1);
    @(negedge clk);
    chk("wr_done_pulse",   32'(done0),  32'd0);
    chk("wr_ready_again",  32'(ready0), 32'd1);

    // Read 0xFD
    frames0.delete(); gaps0.delete();
    accept0(1'b0, 8'hFD, 8'h00, 1'b0);
    wait_done0(1'b0, lat);
    chk("rd_latency", 32'(lat),        32'd38);
    chk("rd_rdata",   32'(rdata0),     32'hFC);
    chk("rd_frame_a", 32'(frames0[0]), 32'({1'b0, 1'b1, 2'b10, 8'hFD, 1'b0}));
    chk("rd_frame_b", 32'(frames0[1]), 32'({1'b0, 1'b1, 2'b11, 8'h00, 1'b0}));
    chk("rd_gap",     32'(gaps0[1]),   32'd1);
    @(negedge clk);

    // Two queued writes with req_valid held high
    frames0.delete(); gaps0.delete();
    accept0(1'b1, 8'h01, 8'hAA, 1'b1);
    addr0 = 8'h02; wdata0 = 8'h55;
    wait_done0(1'b0, lat);
    chk("q1_latency", 32'(lat), 32'd29);
    @(negedge clk);
    chk("q_ready_after_done", 32'(ready0), 32'd1);
    chk("q_no_overlap",       32'(busy0),  32'd0);
    @(negedge clk);
    chk("q2_accepted",        32'(busy0),  32'd1);
    valid0 = 1'b0;
    wait_done0(1'b0, lat);
    chk("q2_latency",   32'(lat),          32'd29);
    chk("q1_mem",       32'(mem[0][8'h01]), 32'hAA);
    chk("q2_mem",       32'(mem[0][8'h02]), 32'h55);
    chk("q2_frame_b",   32'(frames0[3]),   32'({1'b0, 1'b0, 2'b01, 8'h55, 1'b0}));
    chk("q_txn_gap",    32'(gaps0[2] >= 2), 32'd1);
    @(negedge clk);

    // Inputs toggled every cycle after acceptance
    frames0.delete(); gaps0.delete();
    accept0(1'b1, 8'h03, 8'h3C, 1'b0);
    wait_done0(1'b1, lat);
    chk("tog_wr_latency", 32'(lat),           32'd29);
    chk("tog_wr_mem",     32'(mem[0][8'h03]), 32'h3C);
    chk("tog_wr_frame_a", 32'(frames0[0]),    32'({1'b0, 1'b0, 2'b00, 8'h03, 1'b0}));
    @(negedge clk);
    frames0.delete();
    accept0(1'b0, 8'h02, 8'hFF, 1'b0);
    wait_done0(1'b1, lat);
    chk("tog_rd_latency", 32'(lat),        32'd38);
    chk("tog_rd_rdata",   32'(rdata0),     32'h55);
    chk("tog_rd_frame_a", 32'(frames0[0]), 32'({1'b0, 1'b1, 2'b10, 8'h02, 1'b0}));
    @(negedge clk);

    // Reset during frame B, F6 of a read (cycle 21 after acceptance)
    accept0(1'b0, 8'hFD, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    chk("mid_ss_low", 32'(ss_v[0]), 32'd0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("mid_ss_high", 32'(ss_v[0]), 32'd1);
    chk("mid_done",    32'(done0),   32'd0);
    chk("mid_rdata",   32'(rdata0),  32'h00);
    chk("mid_busy",    32'(busy0),   32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    chk("mid_ready_release", 32'(ready0), 32'd1);
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (done0 === 1'b1) pulses++;
    end
    chk("mid_no_done", 32'(pulses), 32'd0);

    // dut1: GAP=3, RD_LAT=2, read 0x10 holding 0x5A
    gaps1.delete();
    valid1 = 1'b1; write1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
    n = 0;
    while (ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d1_accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    valid1 = 1'b0;
    lat = 1;
    while (done1 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("d1_latency", 32'(lat),      32'd43);
    chk("d1_rdata",   32'(rdata1),   32'h5A);
    chk("d1_gap",     32'(gaps1[1]), 32'd3);
    @(negedge clk);
    chk("d1_ready_again", 32'(ready1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
